bin_to_bcd_seq: RTL

- Sequential double-dabble converter that sits directly downstream of the shift-add multiplier.
- Takes the 2N-bit binary product when the multiplier signals finish and produces packed BCD digits for display and logging.
- Converts one bit per clock and uses a load/busy/done handshake, so it can be chained to the multiplier's finish output.

---
 rtl/bin_to_bcd_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Converts one input bit per clock using a load/busy/done handshake, so it can be
// chained directly to an upstream multiplier's finish output.
// Optional build macro: BCD_DIGIT_COUNT_EN adds the registered ndigits output.
module bin_to_bcd_seq #(
   parameter int unsigned W = 16,
   parameter int unsigned D = (W / 3) + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   bin_in,
   input  logic           load,
   output logic           busy,
   output logic           done,
   output logic [D*4-1:0] bcd
`ifdef BCD_DIGIT_COUNT_EN
   ,
   output logic [$clog2(D+1)-1:0] ndigits
`endif
);

   localparam int unsigned BcdW = D * 4;
   localparam int unsigned CntW = $clog2(W + 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [W-1:0]        bin_q, bin_d;
   logic [BcdW-1:0]     dig_q, dig_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [BcdW-1:0]     bcd_q, bcd_d;

   logic [BcdW-1:0]     dig_adj;
   logic [BcdW-1:0]     dig_step;
   logic                accept;
   logic                last_step;

   // Load is only honoured when no conversion is running.
   assign accept    = load && ((state_q == StIdle) || (state_q == StDone));
   assign last_step = (state_q == StShift) && (cnt_q == CntW'(1));

   // One double-dabble step: add-3 on every digit >= 5 (in parallel), then shift in the binary MSB.
   always_comb begin
      dig_adj = dig_q;
      for (int i = 0; i < int'(D); i++) begin
         if (dig_q[i*4 +: 4] >= 4'd5) begin
            dig_adj[i*4 +: 4] = dig_q[i*4 +: 4] + 4'd3;
         end
      end
      // The top bit falls off; the top digit never reaches 8 for the chosen D.
      dig_step = (dig_adj << 1) | BcdW'(bin_q[W-1]);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (load)      state_d = StShift;
         StShift: if (last_step) state_d = StDone;
         StDone:  if (load)      state_d = StShift;
         default:                state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; bcd comes straight from its register.
   always_comb begin
      busy = (state_q == StShift);
      done = (state_q == StDone);
      bcd  = bcd_q;
   end

   // Datapath next-state: capture on accept, step while shifting, publish on the final step.
   always_comb begin
      bin_d = bin_q;
      dig_d = dig_q;
      cnt_d = cnt_q;
      bcd_d = bcd_q;
      if (accept) begin
         bin_d = bin_in;
         dig_d = '0;
         cnt_d = CntW'(W);
      end else if (state_q == StShift) begin
         bin_d = bin_q << 1;
         dig_d = dig_step;
         cnt_d = cnt_q - CntW'(1);
         if (last_step) begin
            bcd_d = dig_step;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q <= '0;
         dig_q <= '0;
         cnt_q <= '0;
         bcd_q <= '0;
      end else begin
         bin_q <= bin_d;
         dig_q <= dig_d;
         cnt_q <= cnt_d;
         bcd_q <= bcd_d;
      end
   end

`ifdef BCD_DIGIT_COUNT_EN
   localparam int unsigned NdW = $clog2(D + 1);

   logic [NdW-1:0] nd_q, nd_d;
   logic [NdW-1:0] nd_calc;

   // Position of the highest nonzero digit plus one; a zero result still shows one digit.
   always_comb begin
      nd_calc = NdW'(1);
      for (int i = 1; i < int'(D); i++) begin
         if (dig_step[i*4 +: 4] != 4'd0) begin
            nd_calc = NdW'(i + 1);
         end
      end
      nd_d = last_step ? nd_calc : nd_q;
   end

   // Digit-count register, updated on the same edge as bcd.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nd_q <= '0;
      end else begin
         nd_q <= nd_d;
      end
   end

   assign ndigits = nd_q;
`endif

endmodule
